if_fetch_unit: RTL and testbench

- Instruction-fetch front end between the instruction ROM port and the decode stage of the pipelined MIPS datapath.
- Owns the fetch PC, issues ROM reads and tags each returned word with its PC.
- Buffers fetched words in a small flushable FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects (branch, jump, exception) from later stages and discards any stale in-flight data.

---
 rtl/if_pkg.sv | 16 +
 rtl/if_inst_fifo.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   RESET_PC_DEF : default first fetch address after reset
//   INST_BYTES   : fetch PC increment per instruction
//   if_entry_t   : one buffered fetch result {pc, inst, adel}
package if_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam int unsigned INST_BYTES   = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } if_entry_t;

endpackage

// File: rtl/if_inst_fifo.sv
// Small synchronous FIFO holding fetched instruction entries.
// Ports:
//   clk_i, rst_i : clock, synchronous active-low reset
//   push         : write push_entry at the tail (caller guarantees space)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; wins over push and pop
//   push_entry   : entry to write
//   count        : number of valid entries (0..FIFO_DEPTH)
//   head         : oldest entry, all-zero when empty
module if_inst_fifo
    import if_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  if_entry_t                     push_entry,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output if_entry_t                     head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    if_entry_t       mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            pop_ok;

    assign pop_ok = pop & (count != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk_i) begin
        if (push && rst_i && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues ROM reads, tags each
// returned word with its PC and buffers it for decode (valid/ready).
// Optional build macro: IF_ADDR_ERR_EN -- misaligned fetch PCs produce an
// address-error entry instead of a ROM read and halt fetch until a redirect.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-low reset
//   rom_ce_o         : ROM read request this cycle
//   rom_addr_o       : word-aligned ROM byte address (driven every cycle)
//   rom_data_i       : ROM data, valid one cycle after the request
//   redirect_i       : flush front end and restart at redirect_pc_i
//   redirect_pc_i    : restart address
//   id_valid_o       : head entry valid
//   id_ready_i       : decode accepts the head
//   id_inst_o/pc_o   : head instruction word and its PC (0 when empty)
//   id_adel_o        : head entry carries an address-error-load exception
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic        id_adel_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic          inflight_q;
    logic          halt_q;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop;
    logic          credit_ok;
    logic          issue;
    logic          rom_req;
    logic          adel_push;
    logic          push;
    if_entry_t     push_entry;
    if_entry_t     head;

    assign pop = id_valid_o & id_ready_i;

    // Entries held plus the word still on its way back, net of this cycle's pop.
    assign occupancy = {1'b0, count}
                     + {{CW{1'b0}}, inflight_q}
                     - {{CW{1'b0}}, pop};
    assign credit_ok = occupancy < DEPTH_V;
    assign issue     = ~redirect_i & ~halt_q & credit_ok;

`ifdef IF_ADDR_ERR_EN
    logic misaligned;
    assign misaligned = pc_q[1:0] != 2'b00;
    assign rom_req    = issue & ~misaligned;
    assign adel_push  = issue & misaligned;

    always_ff @(posedge clk_i) begin
        if (!rst_i || redirect_i) begin
            halt_q <= 1'b0;
        end else if (adel_push) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign rom_req   = issue;
    assign adel_push = 1'b0;
    assign halt_q    = 1'b0;
`endif

    assign rom_ce_o   = rom_req & rst_i;
    assign rom_addr_o = {pc_q[31:2], 2'b00};

    // A response landing in a redirect cycle is stale and is dropped. The
    // address-error push can only follow a redirect/reset, so it never
    // collides with a ROM response.
    assign push = (inflight_q & ~redirect_i) | adel_push;

    always_comb begin
        push_entry = '0;
        if (inflight_q) begin
            push_entry.pc   = req_pc_q;
            push_entry.inst = rom_data_i;
            push_entry.adel = 1'b0;
        end else begin
            push_entry.pc   = pc_q;
            push_entry.inst = 32'h0;
            push_entry.adel = adel_push;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (redirect_i) begin
            pc_q       <= redirect_pc_i;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rom_req;
            if (rom_req) begin
                pc_q     <= pc_q + INST_BYTES;
                req_pc_q <= pc_q;
            end
        end
    end

    if_inst_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_i),
        .push_entry (push_entry),
        .count      (count),
        .head       (head)
    );

    assign id_valid_o = count != '0;
    assign id_inst_o  = head.inst;
    assign id_pc_o    = head.pc;

`ifdef IF_ADDR_ERR_EN
    assign id_adel_o = head.adel;
`else
    logic unused_adel;
    assign unused_adel = head.adel;
    assign id_adel_o   = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] KEY    = 32'h1234_5678;
    localparam int          DEPTH  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        id_adel_o;

    int checks   = 0;
    int failures = 0;

    // observations of the current cycle
    logic        o_valid, o_ce, o_adel, o_pop;
    logic [31:0] o_pc, o_inst, o_addr;
    // model expectations for the current cycle
    logic [31:0] e_pc, e_inst, e_addr;
    // model state: next PC decode should see, next ROM address, words owed
    logic [31:0] exp_pc, exp_addr;
    int          outstanding;

    if_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rom_ce_o      (rom_ce_o),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .id_adel_o     (id_adel_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous ROM: content is address ^ KEY, garbage when not requested.
    always @(posedge clk_i) begin
        if (rom_ce_o === 1'b1) rom_data_i <= rom_addr_o ^ KEY;
        else                   rom_data_i <= 32'hDEAD_BEEF;
    end

    // One cycle: drive inputs while clock is low, sample, advance the model.
    task automatic cyc(input bit rdy, input bit rd, input logic [31:0] rpc, input bit rst_v);
        id_ready_i    = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        rst_i         = rst_v;
        #1;
        o_valid = id_valid_o;
        o_pc    = id_pc_o;
        o_inst  = id_inst_o;
        o_adel  = id_adel_o;
        o_ce    = rom_ce_o;
        o_addr  = rom_addr_o;
        o_pop   = (o_valid === 1'b1) && rdy;
        e_pc    = exp_pc;
        e_inst  = exp_pc ^ KEY;
        e_addr  = exp_addr;
        if (!rst_v) begin
            exp_pc = RST_PC; exp_addr = RST_PC; outstanding = 0;
        end else if (rd) begin
            exp_pc = rpc; exp_addr = {rpc[31:2], 2'b00}; outstanding = 0;
        end else begin
            if (o_pop) begin exp_pc = exp_pc + 32'd4; outstanding--; end
            if (o_ce === 1'b1) begin exp_addr = exp_addr + 32'd4; outstanding++; end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 32'h8000_0000, 1'b0);
            checks++;
            if (o_ce !== 1'b0) begin
                failures++; $display("FAIL reset_ce cyc=%0d got=%b exp=0", i, o_ce);
            end
            if (i > 0) begin
                checks++;
                if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_inst !== 32'h0 || o_adel !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_outputs valid=%b pc=%h inst=%h adel=%b exp all 0",
                             o_valid, o_pc, o_inst, o_adel);
                end
            end
        end
    endtask

    task automatic test_stream();
        int first_ce = -1;
        int first_valid = -1;
        int nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            if (o_ce === 1'b1 && first_ce < 0) first_ce = i;
            if (o_valid === 1'b1 && first_valid < 0) first_valid = i;
            if (o_valid === 1'b1) nvalid++;
            if (o_ce === 1'b1) begin
                checks++;
                if (o_addr !== e_addr) begin
                    failures++; $display("FAIL stream_addr got=%h exp=%h", o_addr, e_addr);
                end
            end
            if (o_pop) begin
                checks++;
                if (o_pc !== e_pc || o_inst !== e_inst) begin
                    failures++;
                    $display("FAIL stream_data pc=%h inst=%h exp pc=%h inst=%h", o_pc, o_inst, e_pc, e_inst);
                end
            end
        end
        checks++;
        if (first_ce != 0) begin
            failures++; $display("FAIL stream_first_ce got=%0d exp=0", first_ce);
        end
        checks++;
        if (first_valid - first_ce != 2) begin
            failures++; $display("FAIL stream_latency got=%0d exp=2", first_valid - first_ce);
        end
        checks++;
        if (nvalid != 10) begin
            failures++; $display("FAIL stream_throughput valid_cycles=%0d exp=10", nvalid);
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10 && pops < 2; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            if (o_pop) pops++;
        end
        checks++;
        if (pops != 2) begin
            failures++; $display("FAIL bp_warmup pops=%0d exp=2", pops);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'hBFC0_0008 || o_inst !== (32'hBFC0_0008 ^ KEY)) begin
                failures++;
                $display("FAIL bp_head valid=%b pc=%h inst=%h exp pc=bfc00008", o_valid, o_pc, o_inst);
            end
            checks++;
            if (outstanding > DEPTH || o_addr !== e_addr) begin
                failures++;
                $display("FAIL bp_credit outstanding=%0d addr=%h exp<=%0d addr=%h", outstanding, o_addr, DEPTH, e_addr);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            if (o_pop) begin
                checks++;
                if (o_pc !== e_pc || o_inst !== e_inst) begin
                    failures++;
                    $display("FAIL bp_release pc=%h inst=%h exp pc=%h inst=%h", o_pc, o_inst, e_pc, e_inst);
                end
            end
        end
    endtask

    task automatic test_redirect();
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (o_valid !== 1'b1) begin
            failures++; $display("FAIL redir_prefill valid=%b exp=1", o_valid);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, (k == 0), 32'h8000_0100, 1'b1);
            checks++;
            case (k)
                0: if (o_ce !== 1'b0) begin
                    failures++; $display("FAIL redir_ce_R got=%b exp=0", o_ce);
                end
                1: if (o_ce !== 1'b1 || o_addr !== 32'h8000_0100 || o_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL redir_R1 ce=%b addr=%h valid=%b exp 1 80000100 0", o_ce, o_addr, o_valid);
                end
                2: if (o_valid !== 1'b0) begin
                    failures++; $display("FAIL redir_R2 valid=%b exp=0", o_valid);
                end
                default: if (o_valid !== 1'b1 || o_pc !== 32'h8000_0100 || o_inst !== (32'h8000_0100 ^ KEY)) begin
                    failures++;
                    $display("FAIL redir_R3 valid=%b pc=%h inst=%h exp pc=80000100", o_valid, o_pc, o_inst);
                end
            endcase
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            if (o_pop) begin
                checks++;
                if (o_pc !== e_pc || o_inst !== e_inst) begin
                    failures++; $display("FAIL redir_stream pc=%h exp=%h", o_pc, e_pc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_pc = '0;
        bit got = 0;
        cyc(1'b1, 1'b1, 32'h9000_0000, 1'b1);
        checks++;
        if (o_ce !== 1'b0) begin
            failures++; $display("FAIL b2b_ce1 got=%b exp=0", o_ce);
        end
        cyc(1'b1, 1'b1, 32'hA000_0000, 1'b1);
        checks++;
        if (o_ce !== 1'b0) begin
            failures++; $display("FAIL b2b_ce2 got=%b exp=0", o_ce);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (o_ce !== 1'b1 || o_addr !== 32'hA000_0000) begin
            failures++; $display("FAIL b2b_addr ce=%b addr=%h exp 1 a0000000", o_ce, o_addr);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            if (o_pop && !got) begin first_pc = o_pc; got = 1; end
            if (o_pop) begin
                checks++;
                if (o_pc !== e_pc || o_inst !== e_inst) begin
                    failures++; $display("FAIL b2b_stream pc=%h exp=%h", o_pc, e_pc);
                end
            end
        end
        checks++;
        if (!got || first_pc !== 32'hA000_0000) begin
            failures++; $display("FAIL b2b_first got=%h exp=a0000000", first_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seen [3];
        logic [31:0] want [3];
        int n = 0;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 12 && n < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            if (o_ce === 1'b1) begin
                checks++;
                if (o_addr !== e_addr) begin
                    failures++; $display("FAIL wrap_addr got=%h exp=%h", o_addr, e_addr);
                end
            end
            if (o_pop) begin seen[n] = o_pc; n++; end
        end
        checks++;
        if (n != 3) begin
            failures++; $display("FAIL wrap_count got=%0d exp=3", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (seen[i] !== want[i]) begin
                failures++; $display("FAIL wrap_pc idx=%0d got=%h exp=%h", i, seen[i], want[i]);
            end
        end
    endtask

`ifdef IF_ADDR_ERR_EN
    task automatic test_addr_err();
        cyc(1'b1, 1'b1, 32'h8000_0002, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (o_ce !== 1'b0 || o_valid !== 1'b0) begin
            failures++; $display("FAIL adel_R1 ce=%b valid=%b exp 0 0", o_ce, o_valid);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_adel !== 1'b1 || o_pc !== 32'h8000_0002 || o_inst !== 32'h0 || o_ce !== 1'b0) begin
            failures++;
            $display("FAIL adel_entry valid=%b adel=%b pc=%h inst=%h ce=%b exp 1 1 80000002 0 0",
                     o_valid, o_adel, o_pc, o_inst, o_ce);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            checks++;
            if (o_ce !== 1'b0 || o_valid !== 1'b0) begin
                failures++; $display("FAIL adel_halt ce=%b valid=%b exp 0 0", o_ce, o_valid);
            end
        end
        cyc(1'b1, 1'b1, 32'h8000_0000, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (o_ce !== 1'b1 || o_addr !== 32'h8000_0000) begin
            failures++; $display("FAIL adel_resume ce=%b addr=%h exp 1 80000000", o_ce, o_addr);
        end
    endtask
`endif

    task automatic test_random();
        int pops = 0;
        for (int i = 0; i < 400; i++) begin
            bit rdy = ($urandom_range(0, 9) < 7);
            bit rd  = ($urandom_range(0, 19) == 0);
            logic [31:0] rpc = $urandom() & 32'hFFFF_FFFC;
            cyc(rdy, rd, rpc, 1'b1);
            if (o_pop) pops++;
            checks++;
            if (o_addr !== e_addr || (rd && o_ce !== 1'b0)) begin
                failures++; $display("FAIL rand_addr addr=%h ce=%b rd=%b exp addr=%h", o_addr, o_ce, rd, e_addr);
            end
            checks++;
            if (outstanding > DEPTH || outstanding < 0) begin
                failures++; $display("FAIL rand_credit outstanding=%0d exp 0..%0d", outstanding, DEPTH);
            end
            checks++;
            if (o_adel !== 1'b0 || (o_valid === 1'b0 && (o_pc !== 32'h0 || o_inst !== 32'h0))) begin
                failures++; $display("FAIL rand_idle valid=%b pc=%h inst=%h adel=%b", o_valid, o_pc, o_inst, o_adel);
            end
            if (o_pop) begin
                checks++;
                if (o_pc !== e_pc || o_inst !== e_inst) begin
                    failures++;
                    $display("FAIL rand_data pc=%h inst=%h exp pc=%h inst=%h", o_pc, o_inst, e_pc, e_inst);
                end
            end
        end
        checks++;
        if (pops < 100) begin
            failures++; $display("FAIL rand_progress pops=%0d exp>=100", pops);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (o_ce !== 1'b0) begin
            failures++; $display("FAIL rstmid_ce0 got=%b exp=0", o_ce);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (o_valid !== 1'b0 || o_ce !== 1'b0 || o_pc !== 32'h0) begin
            failures++; $display("FAIL rstmid_clear valid=%b ce=%b pc=%h exp 0 0 0", o_valid, o_ce, o_pc);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (o_ce !== 1'b1 || o_addr !== RST_PC) begin
            failures++; $display("FAIL rstmid_restart ce=%b addr=%h exp 1 %h", o_ce, o_addr, RST_PC);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            if (o_pop) begin
                checks++;
                if (o_pc !== e_pc || o_inst !== e_inst) begin
                    failures++; $display("FAIL rstmid_stream pc=%h exp=%h", o_pc, e_pc);
                end
            end
        end
    endtask

    initial begin
        exp_pc = RST_PC;
        exp_addr = RST_PC;
        outstanding = 0;
        @(negedge clk_i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
`ifdef IF_ADDR_ERR_EN
        test_addr_err();
`else
        test_random();
`endif
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
